// File: rtl/mul_pkg.sv
// Shared opcodes, controller state encoding and the sign helpers for the HI/LO multiply controller.
package mul_pkg;

  localparam int unsigned MUL_W       = 32;
  localparam int unsigned MUL_W2      = 2 * MUL_W;
  localparam int unsigned MUL_TIMEOUT = 15;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_FIX     = 3'd4,
    ST_ABORT   = 3'd5
  } state_t;

  // Two's-complement magnitude; the most negative value maps onto itself as an unsigned number.
  function automatic logic [MUL_W-1:0] abs_w(input logic [MUL_W-1:0] x);
    return x[MUL_W-1] ? (~x + MUL_W'(1)) : x;
  endfunction

  function automatic logic [MUL_W2-1:0] neg2w(input logic [MUL_W2-1:0] x);
    return ~x + MUL_W2'(1);
  endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Combinational operand magnitude conversion and product sign restoration for signed MULT.
module mul_sign_fix
  import mul_pkg::*;
#(
  parameter int unsigned W = MUL_W
) (
  input  logic           op_signed,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           neg,
  input  logic [2*W-1:0] prod,
  output logic [W-1:0]   mag_a_c,
  output logic [W-1:0]   mag_b_c,
  output logic [2*W-1:0] fixed_c
);

  always_comb begin
    mag_a_c = a;
    mag_b_c = b;
    fixed_c = prod;
    if (op_signed) begin
      mag_a_c = abs_w(a);
      mag_b_c = abs_w(b);
    end
    if (neg) begin
      fixed_c = neg2w(prod);
    end
  end

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Sequences the negedge-pipelined unsigned multiplier core and owns the architectural HI/LO registers.
module mul_hilo_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned W       = MUL_W,
  parameter int unsigned TIMEOUT = MUL_TIMEOUT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  input  logic [1:0]     req_op,
  input  logic [W-1:0]   req_a,
  input  logic [W-1:0]   req_b,
  output logic           req_ready,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo,
  output logic           mul_start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_z,
  input  logic           mul_done,
  output logic           mul_rst,
  output logic           err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t         state;
  logic           neg;
  logic [2*W-1:0] prod;
  logic [CNT_W-1:0] cnt;

  logic [W-1:0]   mag_a_c;
  logic [W-1:0]   mag_b_c;
  logic [2*W-1:0] fixed_c;
  logic           op_signed_c;
  logic           timed_out_c;

  assign op_signed_c = (req_op == OP_MULT);
  assign timed_out_c = (cnt == CNT_W'(TIMEOUT));

  // The core is held in reset with the controller, and pulsed for one cycle when a multiply is aborted.
  assign mul_rst = ~reset | (state == ST_ABORT);

  mul_sign_fix #(.W(W)) u_sign_fix (
    .op_signed (op_signed_c),
    .a         (req_a),
    .b         (req_b),
    .neg       (neg),
    .prod      (prod),
    .mag_a_c   (mag_a_c),
    .mag_b_c   (mag_b_c),
    .fixed_c   (fixed_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      hi        <= '0;
      lo        <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      err       <= 1'b0;
      neg       <= 1'b0;
      prod      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            case (req_op)
              OP_MTHI: hi <= req_a;
              OP_MTLO: lo <= req_a;
              default: begin
                mul_a     <= mag_a_c;
                mul_b     <= mag_b_c;
                neg       <= op_signed_c & (req_a[W-1] ^ req_b[W-1]);
                mul_start <= 1'b1;
                cnt       <= '0;
                req_ready <= 1'b0;
                state     <= ST_ISSUE;
              end
            endcase
          end
        end
        // A done that is still high here is stale; only a fresh low->high sequence completes.
        ST_ISSUE: begin
          if (!mul_done) begin
            cnt   <= cnt + CNT_W'(1);
            state <= ST_WAIT_LO;
          end else if (timed_out_c) begin
            mul_start <= 1'b0;
            err       <= 1'b1;
            state     <= ST_ABORT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // Dropping start together with the capture keeps the core from seeing start after it wraps.
        ST_WAIT_LO: begin
          if (mul_done) begin
            mul_start <= 1'b0;
            prod      <= mul_z;
            state     <= ST_FIX;
          end else if (timed_out_c) begin
            mul_start <= 1'b0;
            err       <= 1'b1;
            state     <= ST_ABORT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_FIX: begin
          {hi, lo}  <= fixed_c;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_ABORT: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          mul_start <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Bench for mul_hilo_ctrl: behavioural negedge core model plus a HI/LO reference built from signed/unsigned arithmetic.
module tb_mul_hilo_ctrl;

  localparam int unsigned W       = 32;
  localparam int unsigned TIMEOUT = 15;
  localparam logic [1:0]  MULTU   = 2'b00;
  localparam logic [1:0]  MULT    = 2'b01;
  localparam logic [1:0]  MTHI    = 2'b10;
  localparam logic [1:0]  MTLO    = 2'b11;

  logic           clk       = 1'b0;
  logic           reset     = 1'b0;
  logic           req_valid = 1'b0;
  logic [1:0]     req_op    = 2'b00;
  logic [W-1:0]   req_a     = '0;
  logic [W-1:0]   req_b     = '0;
  logic           req_ready;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic           mul_start;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] mul_z     = '0;
  logic           mul_done  = 1'b1;
  logic           mul_rst;
  logic           err;

  logic           stuck     = 1'b0;
  logic           core_busy = 1'b0;
  int             core_cnt  = 0;

  int             n_pass    = 0;
  int             n_total   = 0;
  logic [W-1:0]   m_hi      = '0;
  logic [W-1:0]   m_lo      = '0;

  always #5 clk = ~clk;

  mul_hilo_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .hi        (hi),
    .lo        (lo),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_z     (mul_z),
    .mul_done  (mul_done),
    .mul_rst   (mul_rst),
    .err       (err)
  );

  // Core: samples on negedge, done drops after start and rises 7 negedges later with the product.
  always @(negedge clk) begin
    if (mul_rst) begin
      core_busy <= 1'b0;
      core_cnt  <= 0;
      mul_done  <= 1'b1;
    end else if (core_busy) begin
      if (core_cnt == 6) begin
        core_busy <= 1'b0;
        mul_z     <= {32'b0, mul_a} * {32'b0, mul_b};
        mul_done  <= ~stuck;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end else if (mul_start && mul_done) begin
      core_busy <= 1'b1;
      core_cnt  <= 0;
      mul_done  <= 1'b0;
    end
  end

  function automatic logic [63:0] ref_prod(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa;
    longint sb;
    if (op == MULT) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [W-1:0] ref_mag(input logic [1:0] op, input logic [W-1:0] a);
    longint sa;
    sa = longint'($signed(a));
    if (op == MULT && sa < 0) return 32'(-sa);
    return a;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    int n = 0;
    while (!req_ready && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic check_hilo(input string tag);
    check({tag, "_hi"}, 64'(hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(lo), 64'(m_lo));
  endtask

  task automatic run_mul(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag);
    logic [63:0] p;
    int n = 0;
    p = ref_prod(op, a, b);
    accept(op, a, b, tag);
    check({tag, "_start"}, 64'(mul_start), 64'(1));
    check({tag, "_mag_a"}, 64'(mul_a), 64'(ref_mag(op, a)));
    check({tag, "_mag_b"}, 64'(mul_b), 64'(ref_mag(op, b)));
    while (!req_ready && n < 60) begin
      n++;
      tick();
    end
    // Ready returns together with the result, after the 9th posedge.
    check({tag, "_stall"}, 64'(n), 64'(9));
    m_hi = p[63:32];
    m_lo = p[31:0];
    check_hilo(tag);
  endtask

  task automatic move(input logic [1:0] op, input logic [W-1:0] a, input string tag);
    accept(op, a, '0, tag);
    if (op == MTHI) m_hi = a;
    else m_lo = a;
    check_hilo(tag);
  endtask

  initial begin
    int n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [1:0]   rop;

    tick();
    tick();
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_start", 64'(mul_start), 64'(0));
    check("rst_mul_a", 64'(mul_a), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_mul_rst", 64'(mul_rst), 64'(1));
    reset = 1'b1;
    tick();
    check("rst_ready", 64'(req_ready), 64'(1));
    check("rel_mul_rst", 64'(mul_rst), 64'(0));

    run_mul(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check("multu_max_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_max_lo_const", 64'(lo), 64'h0000_0000_0000_0001);
    run_mul(MULT, 32'hFFFF_FFFE, 32'h0000_0003, "mult_neg");
    check("mult_neg_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFA);
    run_mul(MULT, 32'h8000_0000, 32'h8000_0000, "mult_min");
    check("mult_min_hi_const", 64'(hi), 64'h0000_0000_4000_0000);
    run_mul(MULT, 32'h0000_0000, 32'hFFFF_FFFF, "mult_negzero");
    run_mul(MULT, 32'h8000_0000, 32'h0000_0001, "mult_min_pos");

    move(MTHI, 32'h1234_5678, "mthi_b2b");
    move(MTLO, 32'h9ABC_DEF0, "mtlo_b2b");

    // Move presented while a multiply is in flight is held off until the result lands.
    accept(MULTU, 32'h0000_1000, 32'h0000_0100, "hold_mul");
    req_valid = 1'b1;
    req_op    = MTHI;
    req_a     = 32'hCAFE_F00D;
    n = 0;
    while (!req_ready && n < 60) begin
      n++;
      tick();
    end
    m_hi = 32'h0000_0000;
    m_lo = 32'h0010_0000;
    check("hold_stall", 64'(n), 64'(9));
    check_hilo("hold_result");
    tick();
    req_valid = 1'b0;
    m_hi = 32'hCAFE_F00D;
    check_hilo("hold_move");

    // Asynchronous reset in the middle of a MULT.
    accept(MULT, 32'hFFFF_0001, 32'h7000_0003, "mid_rst");
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    m_hi = '0;
    m_lo = '0;
    check_hilo("mid_rst");
    check("mid_rst_start", 64'(mul_start), 64'(0));
    check("mid_rst_mul_rst", 64'(mul_rst), 64'(1));
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'(1));
    check("mid_rst_rel", 64'(mul_rst), 64'(0));
    run_mul(MULTU, 32'd3, 32'd5, "after_rst");

    // Core never signals done: controller must abort on its own.
    move(MTLO, 32'h5555_AAAA, "pre_abort");
    stuck = 1'b1;
    accept(MULTU, 32'h0000_0007, 32'h0000_0009, "abort");
    n = 0;
    while (!mul_rst && n < 60) begin
      tick();
      n++;
    end
    check("abort_latency", 64'(n >= int'(TIMEOUT) && n <= int'(TIMEOUT) + 2), 64'(1));
    check("abort_err", 64'(err), 64'(1));
    check("abort_start", 64'(mul_start), 64'(0));
    check_hilo("abort");
    tick();
    check("abort_pulse", 64'(mul_rst), 64'(0));
    check("abort_ready", 64'(req_ready), 64'(1));
    stuck = 1'b0;
    tick();
    run_mul(MULT, 32'hFFFF_FFFF, 32'h0000_0002, "post_abort");
    check("err_sticky", 64'(err), 64'(1));

    // Randomized mix of multiplies and moves.
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) rb = '0;
      if (rop == MTHI || rop == MTLO) move(rop, ra, "rnd_move");
      else run_mul(rop, ra, rb, "rnd_mul");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
